// File: rtl/carry_look_ahead_adder_if.sv
// Operand/result bundle for carry_look_ahead_adder.
// The master drives the operands and the slave (the adder) drives the results.
interface carry_look_ahead_adder_if #(
  parameter int unsigned CLA_WIDTH = 16
);
  logic [CLA_WIDTH-1:0] a_i;
  logic [CLA_WIDTH-1:0] b_i;
  logic                 carry_i;
  logic [CLA_WIDTH-1:0] sum_o;
  logic                 carry_o;
  logic                 group_p_o;
  logic                 group_g_o;
  logic [CLA_WIDTH-1:0] sum_r_o;
  logic                 carry_r_o;

  modport master (
    output a_i, b_i, carry_i,
    input  sum_o, carry_o, group_p_o, group_g_o, sum_r_o, carry_r_o
  );

  modport slave (
    input  a_i, b_i, carry_i,
    output sum_o, carry_o, group_p_o, group_g_o, sum_r_o, carry_r_o
  );
endinterface

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry look-ahead adder, CLA_WIDTH in 1..64.
// Bits form 4-bit groups; the group lookahead is itself split into blocks of
// 4 groups, so a fixed 64-bit / 16-group / 4-block tree covers every width.
// Bits above CLA_WIDTH are padded as pure propagate (p=1, g=0), so the carry
// into position CLA_WIDTH reaches the top of the tree unchanged. As a result,
// the word P/G and carry-out fall out of the top level for any width.
// The combinational result is also registered for pipelined consumers.
module carry_look_ahead_adder #(
  parameter int unsigned CLA_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  carry_look_ahead_adder_if.slave  bus
);

  logic [63:0]          p_pad;
  logic [63:0]          g_pad;
  logic [15:0]          grp_p;
  logic [15:0]          grp_g;
  logic [3:0]           blk_p;
  logic [3:0]           blk_g;
  logic                 word_p;
  logic                 word_g;
  logic [3:0]           blk_c;
  logic [15:0]          grp_c;
  logic [3:0]           bit_c;
  logic [CLA_WIDTH-1:0] sum;
  logic                 carry_out;
  logic [CLA_WIDTH-1:0] sum_r_d;
  logic [CLA_WIDTH-1:0] sum_r_q;
  logic                 carry_r_d;
  logic                 carry_r_q;

  // Returns {P, G} of four propagate/generate pairs.
  function automatic logic [1:0] pg4(input logic [3:0] p, input logic [3:0] g);
    logic [1:0] r;
    r[1] = &p;
    r[0] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  // Carries into positions 1..3 of a 4-wide slice, flattened sum-of-products.
  function automatic logic [2:0] carries4(input logic [2:0] p, input logic [2:0] g,
                                          input logic ci);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Bit-level propagate/generate, padded up to 64 bits with pure propagate.
  always_comb begin
    p_pad = '1;
    g_pad = '0;
    p_pad[CLA_WIDTH-1:0] = bus.a_i ^ bus.b_i;
    g_pad[CLA_WIDTH-1:0] = bus.a_i & bus.b_i;
  end

  // Level 1: group P/G for each 4-bit group.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      {grp_p[j], grp_g[j]} = pg4(p_pad[4*j +: 4], g_pad[4*j +: 4]);
    end
  end

  // Level 2 upper tier: block P/G over 4 groups, then word P/G over 4 blocks.
  always_comb begin
    blk_p = '0;
    blk_g = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      {blk_p[k], blk_g[k]} = pg4(grp_p[4*k +: 4], grp_g[4*k +: 4]);
    end
    {word_p, word_g} = pg4(blk_p, blk_g);
  end

  // Level 2 carry distribution: block carry-ins, then group carry-ins per block.
  always_comb begin
    blk_c = {carries4(blk_p[2:0], blk_g[2:0], bus.carry_i), bus.carry_i};
    grp_c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      grp_c[4*k +: 4] = {carries4(grp_p[4*k +: 3], grp_g[4*k +: 3], blk_c[k]), blk_c[k]};
    end
  end

  // Level 1 carries inside each group and the sum bits; padding bits are dropped.
  always_comb begin
    sum   = '0;
    bit_c = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      bit_c = {carries4(p_pad[4*j +: 3], g_pad[4*j +: 3], grp_c[j]), grp_c[j]};
      for (int unsigned m = 0; m < 4; m++) begin
        if (4*j + m < CLA_WIDTH) begin
          sum[4*j + m] = p_pad[4*j + m] ^ bit_c[m];
        end
      end
    end
    carry_out = word_g | (word_p & bus.carry_i);
  end

  assign bus.sum_o     = sum;
  assign bus.carry_o   = carry_out;
  assign bus.group_p_o = word_p;
  assign bus.group_g_o = word_g;

  // Next value of the result register.
  always_comb begin
    sum_r_d   = sum;
    carry_r_d = carry_out;
  end

  // Result register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_r_q   <= '0;
      carry_r_q <= 1'b0;
    end else begin
      sum_r_q   <= sum_r_d;
      carry_r_q <= carry_r_d;
    end
  end

  assign bus.sum_r_o   = sum_r_q;
  assign bus.carry_r_o = carry_r_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed and random checks of carry_look_ahead_adder at widths 1, 5, 16, 64.
module tb_carry_look_ahead_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  carry_look_ahead_adder_if #(.CLA_WIDTH(1))  if_w1 ();
  carry_look_ahead_adder_if #(.CLA_WIDTH(5))  if_w5 ();
  carry_look_ahead_adder_if #(.CLA_WIDTH(16)) if_w16 ();
  carry_look_ahead_adder_if #(.CLA_WIDTH(64)) if_w64 ();

  carry_look_ahead_adder #(.CLA_WIDTH(1))  dut_w1  (.clk_i(clk), .rst_i(rst), .bus(if_w1));
  carry_look_ahead_adder #(.CLA_WIDTH(5))  dut_w5  (.clk_i(clk), .rst_i(rst), .bus(if_w5));
  carry_look_ahead_adder #(.CLA_WIDTH(16)) dut_w16 (.clk_i(clk), .rst_i(rst), .bus(if_w16));
  carry_look_ahead_adder #(.CLA_WIDTH(64)) dut_w64 (.clk_i(clk), .rst_i(rst), .bus(if_w64));

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int unsigned w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return m;
  endfunction

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input int unsigned w);
    logic [63:0] m;
    m = wmask(w);
    return {1'b0, a & m} + {1'b0, b & m} + {64'd0, c};
  endfunction

  // Full check of one instance's combinational outputs against a reference add.
  task automatic check_word(input string tag, input int unsigned w,
                            input logic [63:0] a, input logic [63:0] b, input logic c,
                            input logic [64:0] obs, input logic obs_p, input logic obs_g,
                            input logic obs_co);
    logic [64:0] exp_sum;
    logic [64:0] exp_g;
    logic [63:0] m;
    m       = wmask(w);
    exp_sum = ref_add(a, b, c, w);
    exp_g   = ref_add(a, b, 1'b0, w);
    check({tag, " sum"}, obs, exp_sum);
    check({tag, " P"}, 65'(obs_p), 65'(&((a ^ b) | ~m)));
    check({tag, " G"}, 65'(obs_g), 65'(exp_g[w]));
    check({tag, " co identity"}, 65'(obs_co), 65'(obs_g | (obs_p & c)));
  endtask

  task automatic drive_all(input logic [63:0] a, input logic [63:0] b, input logic c);
    if_w1.a_i  = a[0:0];   if_w1.b_i  = b[0:0];   if_w1.carry_i  = c;
    if_w5.a_i  = a[4:0];   if_w5.b_i  = b[4:0];   if_w5.carry_i  = c;
    if_w16.a_i = a[15:0];  if_w16.b_i = b[15:0];  if_w16.carry_i = c;
    if_w64.a_i = a;        if_w64.b_i = b;        if_w64.carry_i = c;
  endtask

  task automatic check_all(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic c);
    check_word({tag, " w1"}, 1, a, b, c, 65'({if_w1.carry_o, if_w1.sum_o}),
               if_w1.group_p_o, if_w1.group_g_o, if_w1.carry_o);
    check_word({tag, " w5"}, 5, a, b, c, 65'({if_w5.carry_o, if_w5.sum_o}),
               if_w5.group_p_o, if_w5.group_g_o, if_w5.carry_o);
    check_word({tag, " w16"}, 16, a, b, c, 65'({if_w16.carry_o, if_w16.sum_o}),
               if_w16.group_p_o, if_w16.group_g_o, if_w16.carry_o);
    check_word({tag, " w64"}, 64, a, b, c, 65'({if_w64.carry_o, if_w64.sum_o}),
               if_w64.group_p_o, if_w64.group_g_o, if_w64.carry_o);
  endtask

  // Hand-computed 16-bit vectors: a, b, cin -> sum, cout, P, G.
  logic [15:0] va [8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h000F,
                          16'h8000, 16'hFFFF, 16'h1234, 16'h00F0};
  logic [15:0] vb [8] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0001,
                          16'h8000, 16'h0000, 16'h4321, 16'hFF10};
  logic        vc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] vs [8] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0010,
                          16'h0000, 16'hFFFF, 16'h5556, 16'h0000};
  logic        vco[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        vp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        vg [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;

    drive_all('0, '0, 1'b0);
    #1;
    check("reset sum_r", 65'(if_w16.sum_r_o), 65'd0);
    check("reset carry_r", 65'(if_w16.carry_r_o), 65'd0);

    for (int i = 0; i < 8; i++) begin
      if_w16.a_i = va[i]; if_w16.b_i = vb[i]; if_w16.carry_i = vc[i];
      #30;
      check($sformatf("dir%0d sum", i), 65'(if_w16.sum_o), 65'(vs[i]));
      check($sformatf("dir%0d carry", i), 65'(if_w16.carry_o), 65'(vco[i]));
      check($sformatf("dir%0d P", i), 65'(if_w16.group_p_o), 65'(vp[i]));
      check($sformatf("dir%0d G", i), 65'(if_w16.group_g_o), 65'(vg[i]));
    end
    check("sum_r held in reset", 65'(if_w16.sum_r_o), 65'd0);

    // Edge cases on every width, then random vectors.
    for (int i = 0; i < 60; i++) begin
      case (i)
        0: begin ra = '1; rb = '0; rc = 1'b1; end
        1: begin ra = '1; rb = '1; rc = 1'b1; end
        2: begin ra = '1; rb = '0; rc = 1'b0; end
        default: begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          rc = 1'($urandom_range(1));
        end
      endcase
      drive_all(ra, rb, rc);
      #30;
      check_all($sformatf("vec%0d", i), ra, rb, rc);
    end

    // Register path: release reset, capture a carry-out.
    @(negedge clk);
    rst = 1'b0;
    if_w16.a_i = 16'hFFFF; if_w16.b_i = 16'h0000; if_w16.carry_i = 1'b1;
    @(posedge clk); #1;
    check("reg wrap sum_r", 65'(if_w16.sum_r_o), 65'h0000);
    check("reg wrap carry_r", 65'(if_w16.carry_r_o), 65'd1);
    @(negedge clk);
    if_w16.a_i = 16'h00FF; if_w16.b_i = 16'h0001; if_w16.carry_i = 1'b0;
    #1;
    check("reg latency hold", 65'(if_w16.sum_r_o), 65'h0000);
    @(posedge clk); #1;
    check("reg sum_r", 65'(if_w16.sum_r_o), 65'h0100);
    check("reg carry_r", 65'(if_w16.carry_r_o), 65'd0);

    // Asynchronous reset mid-cycle.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst sum_r", 65'(if_w16.sum_r_o), 65'd0);
    check("async rst carry_r", 65'(if_w16.carry_r_o), 65'd0);
    if_w16.a_i = 16'h1234; if_w16.b_i = 16'h4321; if_w16.carry_i = 1'b1;
    #1;
    check("comb during rst", 65'(if_w16.sum_o), 65'h5556);
    @(posedge clk); #1;
    check("rst held sum_r", 65'(if_w16.sum_r_o), 65'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post rst sum_r", 65'(if_w16.sum_r_o), 65'h5556);
    check("post rst carry_r", 65'(if_w16.carry_r_o), 65'd0);
    if_w16.a_i = 16'h0001; if_w16.b_i = 16'h0001; if_w16.carry_i = 1'b0;
    #2;
    check("no early capture", 65'(if_w16.sum_r_o), 65'h5556);
    @(posedge clk); #1;
    check("next capture", 65'(if_w16.sum_r_o), 65'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
